// File: rtl/seven_seg_capture_if.sv
// Seven-segment display bus as seen by a capture block: pins in, recovered frame out.
interface seven_seg_capture_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_done;
    logic        frame_valid;

    // Scanner side drives the pins and observes the recovered frame.
    modport master (
        output seg, an,
        input  digits, digit_err, frame_done, frame_valid
    );

    // Capture side samples the pins and produces the recovered frame.
    modport slave (
        input  seg, an,
        output digits, digit_err, frame_done, frame_valid
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Recovers the four BCD digits shown on a multiplexed active-low 7-segment bus.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TIMEOUT_W     = 20
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_capture_if.slave bus
);
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned AN_W   = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned NDIG   = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DIG_W  = CODE_W * NDIG;

    localparam logic [CNT_W-1:0]     STAB_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TO_MAX   = '1;

    logic [SEG_W-1:0]     s_seg, p_seg;
    logic [AN_W-1:0]      s_an, p_an;
    logic [CNT_W-1:0]     stab_cnt, stab_nxt_c;
    logic                 captured, captured_nxt_c;
    logic [NDIG-1:0]      seen, seen_nxt_c;
    logic [TIMEOUT_W-1:0] to_cnt, to_nxt_c;
    logic [DIG_W-1:0]     digits_q, digits_nxt_c;
    logic [NDIG-1:0]      err_q, err_nxt_c;
    logic                 done_q, done_nxt_c;
    logic                 valid_q, valid_nxt_c;

    logic                 sel_ok_c;
    logic [1:0]           idx_c;
    logic [NDIG-1:0]      sel_bit_c;
    logic                 changed_c;
    logic                 capture_c;
    logic [CODE_W-1:0]    code_c;
    logic                 code_err_c;

    // Pin sampling plus a one-cycle-delayed copy for change detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg <= '1;
            s_an  <= '1;
            p_seg <= '1;
            p_an  <= '1;
        end else begin
            s_seg <= bus.seg;
            s_an  <= bus.an;
            p_seg <= s_seg;
            p_an  <= s_an;
        end
    end

    // Exactly one low anode selects a digit; anything else is idle.
    always_comb begin
        sel_ok_c = 1'b1;
        idx_c    = 2'd0;
        case (s_an)
            4'b1110: idx_c = 2'd0;
            4'b1101: idx_c = 2'd1;
            4'b1011: idx_c = 2'd2;
            4'b0111: idx_c = 2'd3;
            default: sel_ok_c = 1'b0;
        endcase
        sel_bit_c = NDIG'(1) << idx_c;
    end

    // Segment pattern to BCD; blank reads as F, unknown shapes as E with error.
    always_comb begin
        code_err_c = 1'b0;
        case (s_seg)
            7'b1000000: code_c = 4'h0;
            7'b1111001: code_c = 4'h1;
            7'b0100100: code_c = 4'h2;
            7'b0110000: code_c = 4'h3;
            7'b0011001: code_c = 4'h4;
            7'b0010010: code_c = 4'h5;
            7'b0000010: code_c = 4'h6;
            7'b1111000: code_c = 4'h7;
            7'b0000000: code_c = 4'h8;
            7'b0010000: code_c = 4'h9;
            7'b1111111: code_c = 4'hF;
            default: begin
                code_c     = 4'hE;
                code_err_c = 1'b1;
            end
        endcase
    end

    // Dwell filter, single capture per dwell, frame assembly and stale timeout.
    always_comb begin
        stab_nxt_c     = stab_cnt;
        captured_nxt_c = captured;
        seen_nxt_c     = seen;
        to_nxt_c       = to_cnt;
        digits_nxt_c   = digits_q;
        err_nxt_c      = err_q;
        done_nxt_c     = 1'b0;
        valid_nxt_c    = valid_q;

        changed_c = ({s_an, s_seg} != {p_an, p_seg});

        if (!sel_ok_c || changed_c) begin
            stab_nxt_c = '0;
        end else if (stab_cnt != STAB_MAX) begin
            stab_nxt_c = stab_cnt + CNT_W'(1);
        end

        // Fires only on the cycle the count first arrives at the threshold.
        capture_c = sel_ok_c && !captured && (stab_cnt != STAB_MAX) &&
                    (stab_nxt_c == STAB_MAX);

        if (changed_c) begin
            captured_nxt_c = 1'b0;
        end else if (capture_c) begin
            captured_nxt_c = 1'b1;
        end

        if (capture_c) begin
            to_nxt_c = '0;
        end else if (to_cnt != TO_MAX) begin
            to_nxt_c = to_cnt + TIMEOUT_W'(1);
        end

        if (capture_c) begin
            digits_nxt_c[{idx_c, 2'b00} +: CODE_W] = code_c;
            err_nxt_c[idx_c]                       = code_err_c;
            if ((seen | sel_bit_c) == '1) begin
                done_nxt_c  = 1'b1;
                seen_nxt_c  = '0;
                valid_nxt_c = 1'b1;
            end else begin
                seen_nxt_c = seen | sel_bit_c;
            end
        end else if (to_nxt_c == TO_MAX) begin
            valid_nxt_c = 1'b0;
            seen_nxt_c  = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt <= '0;
            captured <= 1'b0;
            seen     <= '0;
            to_cnt   <= '0;
            digits_q <= '1;
            err_q    <= '0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            stab_cnt <= stab_nxt_c;
            captured <= captured_nxt_c;
            seen     <= seen_nxt_c;
            to_cnt   <= to_nxt_c;
            digits_q <= digits_nxt_c;
            err_q    <= err_nxt_c;
            done_q   <= done_nxt_c;
            valid_q  <= valid_nxt_c;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_valid = valid_q;

endmodule
